// File: rtl/ifid_skid_buffer_pkg.sv
// Shared types and constants for the IF/ID skid buffer.
package ifid_skid_buffer_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b01,
        StFull  = 2'b10
    } ifid_state_e;

    localparam logic [31:0] NOP            = 32'h0000_0000;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 32;

endpackage

// File: rtl/ifid_data_reg.sv
// Enable register with async active-low reset and synchronous clear to NOP.
module ifid_data_reg
    import ifid_skid_buffer_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Clear wins over load so a flush always leaves NOPs behind.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= W'(NOP);
        end else if (i_clr) begin
            r_q <= W'(NOP);
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ifid_skid_buffer.sv
// Two-entry elastic IF/ID register with flush.
// Optional back-pressure counter enabled by defining IFID_STALL_CNT_EN.
module ifid_skid_buffer
    import ifid_skid_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_instruction,
    input  logic [ADDR_W-1:0] i_in_pc,
    input  logic              i_flush,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_instruction,
    output logic [ADDR_W-1:0] o_out_pc,
    output logic [31:0]       o_stall_count
);

    localparam int unsigned ENTRY_W = DATA_W + ADDR_W;

    ifid_state_e        r_state;
    ifid_state_e        w_state_d;
    logic               r_in_ready;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_main_en;
    logic               w_skid_en;
    logic               w_main_sel_skid;
    logic [ENTRY_W-1:0] w_in_entry;
    logic [ENTRY_W-1:0] w_main_d;
    logic [ENTRY_W-1:0] w_main_q;
    logic [ENTRY_W-1:0] w_skid_q;

    assign w_in_entry  = {i_in_pc, i_in_instruction};
    assign o_out_valid = (r_state != StEmpty);
    assign o_in_ready  = r_in_ready;
    assign w_in_fire   = i_in_valid & r_in_ready;
    assign w_out_fire  = o_out_valid & i_out_ready;
    assign w_main_d    = w_main_sel_skid ? w_skid_q : w_in_entry;

    always_comb begin
        w_state_d       = r_state;
        w_main_en       = 1'b0;
        w_skid_en       = 1'b0;
        w_main_sel_skid = 1'b0;
        unique case (r_state)
            StEmpty: begin
                if (w_in_fire) begin
                    w_main_en = 1'b1;
                    w_state_d = StBusy;
                end
            end
            StBusy: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_en = 1'b1;
                end else if (w_in_fire) begin
                    w_skid_en = 1'b1;
                    w_state_d = StFull;
                end else if (w_out_fire) begin
                    w_state_d = StEmpty;
                end
            end
            StFull: begin
                if (w_out_fire) begin
                    w_main_en       = 1'b1;
                    w_main_sel_skid = 1'b1;
                    w_state_d       = StBusy;
                end
            end
            default: w_state_d = StEmpty;
        endcase
        // Data registers see the flush through their clear input.
        if (i_flush) begin
            w_state_d = StEmpty;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StEmpty;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_in_ready <= (w_state_d != StFull);
        end
    end

    ifid_data_reg #(
        .W (ENTRY_W)
    ) u_main (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_flush),
        .i_en    (w_main_en),
        .i_d     (w_main_d),
        .o_q     (w_main_q)
    );

    ifid_data_reg #(
        .W (ENTRY_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_flush),
        .i_en    (w_skid_en),
        .i_d     (w_in_entry),
        .o_q     (w_skid_q)
    );

    assign o_out_pc          = w_main_q[ENTRY_W-1:DATA_W];
    assign o_out_instruction = w_main_q[DATA_W-1:0];

`ifdef IFID_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (o_out_valid && !i_out_ready && !i_flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_count = r_stall_cnt;
`else
    assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_ifid_skid_buffer.sv
// Directed, table-driven bench for ifid_skid_buffer.
module tb_ifid_skid_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] stall_count;

    int n_pass  = 0;
    int n_total = 0;

    ifid_skid_buffer #(
        .DATA_W (32),
        .ADDR_W (32)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_in_valid        (in_valid),
        .o_in_ready        (in_ready),
        .i_in_instruction  (in_instr),
        .i_in_pc           (in_pc),
        .i_flush           (flush),
        .o_out_valid       (out_valid),
        .i_out_ready       (out_ready),
        .o_out_instruction (out_instr),
        .o_out_pc          (out_pc),
        .o_stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        fl;
        logic        ordy;
        logic        ov;
        logic        ir;
        logic        cd;
        logic [31:0] epc;
        logic [31:0] einstr;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic fl,
                                input logic ordy, input logic ov, input logic ir,
                                input logic cd, input logic [31:0] epc, input logic ezero);
        vec_t v;
        v.iv     = iv;
        v.pc     = pc;
        v.fl     = fl;
        v.ordy   = ordy;
        v.ov     = ov;
        v.ir     = ir;
        v.cd     = cd;
        v.epc    = epc;
        v.einstr = ezero ? 32'h0 : instr_of(epc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step(input logic iv, input logic [31:0] pc, input logic fl, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Streaming, back-pressure, flush while full, flush with out fire.
        vecs[0]  = mk(1, 32'h00, 0, 1, 1, 1, 1, 32'h00, 0);
        vecs[1]  = mk(1, 32'h04, 0, 1, 1, 1, 1, 32'h04, 0);
        vecs[2]  = mk(1, 32'h08, 0, 1, 1, 1, 1, 32'h08, 0);
        vecs[3]  = mk(0, 32'h00, 0, 1, 0, 1, 0, 32'h00, 0);
        vecs[4]  = mk(1, 32'h00, 0, 0, 1, 1, 1, 32'h00, 0);
        vecs[5]  = mk(1, 32'h04, 0, 0, 1, 0, 1, 32'h00, 0);
        vecs[6]  = mk(1, 32'h08, 0, 0, 1, 0, 1, 32'h00, 0);
        vecs[7]  = mk(1, 32'h08, 0, 1, 1, 1, 1, 32'h04, 0);
        vecs[8]  = mk(1, 32'h08, 0, 1, 1, 1, 1, 32'h08, 0);
        vecs[9]  = mk(0, 32'h00, 0, 1, 0, 1, 0, 32'h00, 0);
        vecs[10] = mk(1, 32'h10, 0, 0, 1, 1, 1, 32'h10, 0);
        vecs[11] = mk(1, 32'h14, 0, 0, 1, 0, 1, 32'h10, 0);
        vecs[12] = mk(1, 32'h0C, 1, 0, 0, 1, 1, 32'h00, 1);
        vecs[13] = mk(0, 32'h00, 0, 1, 0, 1, 1, 32'h00, 1);
        vecs[14] = mk(1, 32'h20, 0, 1, 1, 1, 1, 32'h20, 0);
        vecs[15] = mk(1, 32'h24, 1, 1, 0, 1, 1, 32'h00, 1);
        vecs[16] = mk(0, 32'h00, 0, 1, 0, 1, 1, 32'h00, 1);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_pc", out_pc, 32'h0);
        chk("reset out_instr", out_instr, 32'h0);
        chk("reset stall_count", stall_count, 32'h0);
        step(0, 32'h0, 0, 0);
        chk("idle in_ready", 32'(in_ready), 32'd1);
        chk("idle out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].iv, vecs[i].pc, vecs[i].fl, vecs[i].ordy);
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
            if (vecs[i].cd) begin
                chk($sformatf("vec%0d out_pc", i), out_pc, vecs[i].epc);
                chk($sformatf("vec%0d out_instr", i), out_instr, vecs[i].einstr);
            end
        end

        // Stall counter: one load, then five held cycles under back-pressure.
        step(1, 32'h40, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 32'h0, 0, 0);
        chk("stall hold out_pc", out_pc, 32'h40);
        chk("stall hold out_valid", 32'(out_valid), 32'd1);
`ifdef IFID_STALL_CNT_EN
        chk("stall_count", stall_count, 32'd5);
`else
        chk("stall_count", stall_count, 32'd0);
`endif

        // Asynchronous reset while FULL.
        step(1, 32'h44, 0, 0);
        chk("full in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        chk("async rst out_pc", out_pc, 32'h0);
        chk("async rst out_instr", out_instr, 32'h0);
        chk("async rst stall_count", stall_count, 32'h0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 0, 1);
            chk($sformatf("post rst%0d out_valid", i), 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
